// File: rtl/tx_symbols_pkg.sv
// Shared symbol constants, framer state encoding and lane-broadcast helper
// for the transmit lane framer.
package tx_symbols_pkg;

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h7C;
    localparam logic [7:0] SYM_FTS = 8'h3C;
    localparam logic [7:0] SYM_COM = 8'hBC;

    // Widest lane count the broadcast helper supports; callers truncate.
    localparam int MAX_LANES = 16;

    typedef enum logic [2:0] {
        IDLE,
        STP,
        DATA,
        DROP,
        END,
        SKP_COM,
        SKP
    } state_t;

    function automatic logic [8*MAX_LANES-1:0] replicate_sym(input logic [7:0] sym);
        return {MAX_LANES{sym}};
    endfunction

endpackage

// File: rtl/skp_scheduler.sv
// Free-running SKP interval counter; raises a sticky request on each wrap
// and flags a request that lands while the previous one is still waiting.
module skp_scheduler #(
    parameter int INTERVAL = 1180
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic pending,
    output logic overrun
);

    localparam int W = $clog2(INTERVAL);
    localparam logic [W-1:0] LAST = W'(INTERVAL - 1);

    logic [W-1:0] count;
    logic         wrap;

    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            count   <= wrap ? '0 : count + W'(1);
            overrun <= wrap && pending;
            // A fresh request wins over the clear issued by SKP_COM.
            if (wrap)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_lane_framer.sv
// Frames a packet stream onto LANES byte lanes with STP/END/EDB delimiters,
// IDL filler and periodic COM+SKP ordered sets taken only between packets.
module tx_lane_framer
    import tx_symbols_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   out_k,
    output logic               out_valid,
    output logic               skp_overrun
);

    state_t     state;
    logic [1:0] seq_cnt;
    logic       skp_pending;
    logic       skp_clear;

    function automatic logic [8*LANES-1:0] bcast(input logic [7:0] sym);
        return (8*LANES)'(replicate_sym(sym));
    endfunction

    assign in_ready  = (state == DATA) || (state == DROP);
    assign skp_clear = (state == SKP_COM);

    skp_scheduler #(
        .INTERVAL (SKP_INTERVAL)
    ) u_skp_scheduler (
        .clk     (clk),
        .reset   (reset),
        .clear   (skp_clear),
        .pending (skp_pending),
        .overrun (skp_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            seq_cnt   <= '0;
            out_data  <= bcast(SYM_IDL);
            out_k     <= '1;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first, then per-state overrides; the
            // last assignment in program order wins, so every path registers a
            // defined value and no path needs a full else-chain.
            out_data  <= bcast(SYM_IDL);
            out_k     <= '1;
            out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (skp_pending)
                        state <= SKP_COM;
                    else if (in_valid)
                        state <= STP;
                end
                STP: begin
                    out_data <= bcast(SYM_STP);
                    state    <= DATA;
                end
                DATA: begin
                    if (in_valid) begin
                        out_data  <= in_data;
                        out_k     <= '0;
                        out_valid <= 1'b1;
                        if (in_last)
                            state <= END;
                    end else begin
                        out_data <= bcast(SYM_EDB);
                        state    <= DROP;
                    end
                end
                DROP: begin
                    // Remainder of an aborted packet is swallowed until its last word.
                    if (in_valid && in_last)
                        state <= IDLE;
                end
                END: begin
                    out_data <= bcast(SYM_END);
                    state    <= IDLE;
                end
                SKP_COM: begin
                    out_data <= bcast(SYM_COM);
                    seq_cnt  <= 2'(SKP_LEN - 1);
                    state    <= SKP;
                end
                SKP: begin
                    out_data <= bcast(SYM_SKP);
                    if (seq_cnt == 2'd0)
                        state <= IDLE;
                    else
                        seq_cnt <= seq_cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_lane_framer.sv
// Randomised and directed bench for tx_lane_framer against a queue-based
// symbol-stream reference model.
module tb_tx_lane_framer;

    localparam int LANES        = 2;
    localparam int SKP_INTERVAL = 16;
    localparam int SKP_LEN      = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_k;
    logic        out_valid;
    logic        skp_overrun;

    always #5 clk = ~clk;

    tx_lane_framer #(
        .LANES        (LANES),
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_LEN      (SKP_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_k       (out_k),
        .out_valid   (out_valid),
        .skp_overrun (skp_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int obs_com  = 0;
    int obs_skp  = 0;
    int obs_ovr  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending control symbols plus packet/drop flags.
    logic [7:0]  ctrl_q[$];
    bit          m_in_pkt;
    bit          m_drop;
    bit          m_pend;
    int          m_cyc;
    logic [15:0] e_data;
    logic [1:0]  e_k;
    logic        e_valid;
    logic        e_ovr;

    function automatic logic [15:0] bc(input logic [7:0] s);
        return {s, s};
    endfunction

    function automatic bit model_ready();
        return (m_in_pkt || m_drop) && (ctrl_q.size() == 0);
    endfunction

    task automatic model_reset();
        ctrl_q.delete();
        m_in_pkt = 1'b0;
        m_drop   = 1'b0;
        m_pend   = 1'b0;
        m_cyc    = 0;
        e_data   = bc(8'h7C);
        e_k      = 2'b11;
        e_valid  = 1'b0;
        e_ovr    = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic l, input logic [15:0] d);
        bit         old_p;
        bit         took_com;
        bit         wrap;
        logic [7:0] s;
        old_p    = m_pend;
        took_com = 1'b0;
        wrap     = (m_cyc % SKP_INTERVAL) == (SKP_INTERVAL - 1);
        e_data   = bc(8'h7C);
        e_k      = 2'b11;
        e_valid  = 1'b0;
        if (ctrl_q.size() > 0) begin
            s        = ctrl_q.pop_front();
            e_data   = bc(s);
            took_com = (s == 8'hBC);
        end else if (m_in_pkt) begin
            if (v) begin
                e_data  = d;
                e_k     = 2'b00;
                e_valid = 1'b1;
                if (l) begin
                    m_in_pkt = 1'b0;
                    ctrl_q.push_back(8'hFD);
                end
            end else begin
                e_data   = bc(8'hFE);
                m_in_pkt = 1'b0;
                m_drop   = 1'b1;
            end
        end else if (m_drop) begin
            if (v && l)
                m_drop = 1'b0;
        end else if (old_p) begin
            ctrl_q.push_back(8'hBC);
            for (int i = 0; i < SKP_LEN; i++)
                ctrl_q.push_back(8'h1C);
        end else if (v) begin
            ctrl_q.push_back(8'hFB);
            m_in_pkt = 1'b1;
        end
        e_ovr = wrap && old_p;
        if (wrap)
            m_pend = 1'b1;
        else if (took_com)
            m_pend = 1'b0;
        m_cyc++;
    endtask

    // One clock: drive, predict, advance, compare.
    task automatic tick(input logic v, input logic l, input logic [15:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        check("in_ready", in_ready, model_ready());
        model_step(v, l, d);
        @(posedge clk);
        #1;
        check("out_data", out_data, e_data);
        check("out_k", out_k, e_k);
        check("out_valid", out_valid, e_valid);
        check("skp_overrun", skp_overrun, e_ovr);
        if (out_data == 16'hBCBC) obs_com++;
        if (out_data == 16'h1C1C && out_k == 2'b11) obs_skp++;
        if (skp_overrun) obs_ovr++;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        check("rst_data", out_data, 16'h7C7C);
        check("rst_k", out_k, 2'b11);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ovr", skp_overrun, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, 16'h0);
    endtask

    // Source holds each word until the handshake completes; gap_pct drops valid.
    task automatic send_pkt(input int len, input int gap_pct);
        int          idx;
        int          guard;
        logic        v;
        logic [15:0] d;
        bit          acc;
        idx   = 0;
        guard = 0;
        d     = 16'($urandom);
        while (idx < len && guard < 400) begin
            v   = ($urandom_range(0, 99) >= gap_pct);
            acc = v && model_ready();
            tick(v, (idx == len - 1), d);
            if (acc) begin
                idx++;
                d = 16'($urandom);
            end
            guard++;
        end
        check("pkt_done", idx, len);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);

        // Two-word packet from IDLE.
        tick(1'b1, 1'b0, 16'h1122);
        check("pkt_idl", out_data, 16'h7C7C);
        tick(1'b1, 1'b0, 16'h1122);
        check("pkt_stp", out_data, 16'hFBFB);
        check("pkt_stp_k", out_k, 2'b11);
        tick(1'b1, 1'b0, 16'h1122);
        check("pkt_w0", out_data, 16'h1122);
        check("pkt_w0_v", out_valid, 1'b1);
        tick(1'b1, 1'b1, 16'h3344);
        check("pkt_w1", out_data, 16'h3344);
        tick(1'b0, 1'b0, 16'h0);
        check("pkt_end", out_data, 16'hFDFD);
        tick(1'b0, 1'b0, 16'h0);
        check("pkt_after", out_data, 16'h7C7C);

        // Underflow after first word of a 3-word packet.
        tick(1'b1, 1'b0, 16'hA1A1);
        tick(1'b1, 1'b0, 16'hA1A1);
        tick(1'b1, 1'b0, 16'hA1A1);
        tick(1'b0, 1'b0, 16'h0);
        check("edb", out_data, 16'hFEFE);
        tick(1'b1, 1'b0, 16'hA2A2);
        check("drop_w2", out_valid, 1'b0);
        tick(1'b1, 1'b1, 16'hA3A3);
        check("drop_w3", out_data, 16'h7C7C);
        tick(1'b0, 1'b0, 16'h0);
        check("drop_no_end", out_data, 16'h7C7C);

        // Idle SKP cadence: two ordered sets within 40 cycles of reset.
        do_reset(2);
        obs_com = 0;
        obs_skp = 0;
        idle(40);
        check("idle_com_count", obs_com, 2);
        check("idle_skp_count", obs_skp, 2 * SKP_LEN);

        // Long packet spanning two wraps: one overrun, one SKP set after END.
        do_reset(2);
        obs_com = 0;
        obs_ovr = 0;
        send_pkt(36, 0);
        check("long_no_com_inside", obs_com, 0);
        check("long_ovr_count", obs_ovr, 1);
        obs_com = 0;
        idle(10);
        check("long_com_after", obs_com, 1);

        // Reset mid-packet; counter restarts so SKP lands 16 cycles later.
        do_reset(2);
        tick(1'b1, 1'b0, 16'h5555);
        tick(1'b1, 1'b0, 16'h5555);
        tick(1'b1, 1'b0, 16'h5555);
        tick(1'b1, 1'b0, 16'h6666);
        do_reset(1);
        obs_com = 0;
        idle(16);
        check("rst_mid_no_com", obs_com, 0);
        idle(2);
        check("rst_mid_com", obs_com, 1);

        // Random traffic.
        for (int p = 0; p < 150; p++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                              : int'($urandom_range(1, 8));
            send_pkt(len, ($urandom_range(0, 3) == 0) ? 8 : 0);
            idle(int'($urandom_range(0, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
